// File: rtl/monitor_contador_pkg.sv
// Shared types for the counter event monitor: event codes, FSM states, event record.
// No logic of its own; pure type and constant definitions.
// Not applicable (no handshake in a package).
package monitor_contador_pkg;

    // Widest counter value an event record can carry; narrower values are zero-extended.
    localparam int MON_VALUE_W = 32;

    typedef enum logic [1:0] {
        EVT_NONE    = 2'b00,
        EVT_WRAP_UP = 2'b01,
        EVT_WRAP_DN = 2'b10,
        EVT_THRESH  = 2'b11
    } evt_code_t;

    typedef enum logic {
        IDLE  = 1'b0,
        TRACK = 1'b1
    } mon_state_t;

    typedef struct packed {
        evt_code_t              code;
        logic [MON_VALUE_W-1:0] value;
    } evt_rec_t;

endpackage

// File: rtl/fifo_eventos.sv
// Generic show-ahead synchronous FIFO carrying one record of type T per entry.
// Latency: a push at edge N is visible at the head in cycle N+1; head reads zero when empty.
// Backpressure: push while full is dropped (o_drop) unless a pop happens in the same cycle.
module fifo_eventos #(
    parameter int  DEPTH = 4,
    parameter type T     = logic [7:0]
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   i_push,
    input  T                       i_push_dat,
    input  logic                   i_pop,
    output T                       o_head_dat,
    output logic                   o_empty,
    output logic                   o_full,
    output logic [$clog2(DEPTH):0] o_count,
    output logic                   o_drop
);

    localparam int PW = $clog2(DEPTH);

    T                r_mem [DEPTH];
    logic [PW-1:0]   r_wr_ptr;
    logic [PW-1:0]   r_rd_ptr;
    logic [PW:0]     r_count;

    logic            w_pop_ok;
    logic            w_push_ok;

    assign o_empty   = (r_count == '0);
    assign o_full    = (r_count == (PW+1)'(DEPTH));
    // A pop on an empty FIFO is ignored; a full FIFO still accepts a push if it is popped too.
    assign w_pop_ok  = i_pop && !o_empty;
    assign w_push_ok = i_push && (!o_full || w_pop_ok);
    assign o_drop    = i_push && !w_push_ok;
    assign o_count   = r_count;
    assign o_head_dat = o_empty ? T'('0) : r_mem[r_rd_ptr];

    // Pointer and occupancy bookkeeping; pointers wrap naturally since DEPTH is a power of 2.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage array; contents need no reset because occupancy gates the head.
    always_ff @(posedge clk) begin
        if (w_push_ok) r_mem[r_wr_ptr] <= i_push_dat;
    end

endmodule

// File: rtl/monitor_contador.sv
// Watches an up/down counter and queues wrap events (and threshold hits with MONITOR_THRESH_EN).
// Latency: event from the sample at edge N appears on evt_valid in cycle N+1.
// Backpressure: evt_ready stalls the head; events arriving into a full queue are dropped and set evt_ovf.
module monitor_contador
    import monitor_contador_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [WIDTH-1:0]       cnt_value,
    input  logic                   cnt_en,
    input  logic                   cnt_dir,
    input  logic [WIDTH-1:0]       thresh,
    output logic                   evt_valid,
    input  logic                   evt_ready,
    output logic [1:0]             evt_code,
    output logic [WIDTH-1:0]       evt_value,
    output logic [$clog2(DEPTH):0] evt_count,
    output logic                   evt_ovf
);

    localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};

    mon_state_t       r_state;
    mon_state_t       w_state_nxt;
    logic [WIDTH-1:0] r_prev;
    logic [WIDTH-1:0] w_prev_nxt;
    logic             r_ovf;

    logic             w_wrap_up;
    logic             w_wrap_dn;
    logic             w_thr_hit;
    logic             w_evt_vld;
    evt_code_t        w_evt_code;
    evt_rec_t         w_rec;
    evt_rec_t         w_head;
    logic             w_empty;
    logic             w_full;
    logic             w_drop;
    logic             w_unused_head;

    assign w_wrap_up = (r_prev == ALL_ONES) && (cnt_value == '0) && !cnt_dir;
    assign w_wrap_dn = (r_prev == '0) && (cnt_value == ALL_ONES) && cnt_dir;

`ifdef MONITOR_THRESH_EN
    // Fires on the cycle the count lands on the threshold, not while it sits there.
    assign w_thr_hit = (cnt_value == thresh) && (r_prev != thresh);
`else
    logic w_unused_thresh;
    assign w_thr_hit       = 1'b0;
    assign w_unused_thresh = ^thresh;
`endif

    // State and previous-sample registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_prev  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_prev  <= w_prev_nxt;
        end
    end

    // Next-state and detection; disabling drops to IDLE so the forced clear never looks like a wrap.
    always_comb begin
        w_state_nxt = r_state;
        w_prev_nxt  = r_prev;
        w_evt_vld   = 1'b0;
        w_evt_code  = EVT_NONE;
        case (r_state)
            IDLE: begin
                if (cnt_en) begin
                    w_state_nxt = TRACK;
                    w_prev_nxt  = cnt_value;
                end
            end
            TRACK: begin
                if (!cnt_en) begin
                    w_state_nxt = IDLE;
                end else begin
                    w_prev_nxt = cnt_value;
                    if (w_wrap_up) begin
                        w_evt_vld  = 1'b1;
                        w_evt_code = EVT_WRAP_UP;
                    end else if (w_wrap_dn) begin
                        w_evt_vld  = 1'b1;
                        w_evt_code = EVT_WRAP_DN;
                    end else if (w_thr_hit) begin
                        w_evt_vld  = 1'b1;
                        w_evt_code = EVT_THRESH;
                    end
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    assign w_rec.code  = w_evt_code;
    assign w_rec.value = MON_VALUE_W'(cnt_value);

    fifo_eventos #(
        .DEPTH (DEPTH),
        .T     (evt_rec_t)
    ) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .i_push     (w_evt_vld),
        .i_push_dat (w_rec),
        .i_pop      (evt_ready),
        .o_head_dat (w_head),
        .o_empty    (w_empty),
        .o_full     (w_full),
        .o_count    (evt_count),
        .o_drop     (w_drop)
    );

    // Sticky overflow; only reset clears it.
    always_ff @(posedge clk) begin
        if (reset) r_ovf <= 1'b0;
        else if (w_drop) r_ovf <= 1'b1;
    end

    assign evt_valid     = !w_empty;
    assign evt_code      = w_head.code;
    assign evt_value     = w_head.value[WIDTH-1:0];
    assign evt_ovf       = r_ovf;
    // Record bits above WIDTH are always zero here.
    assign w_unused_head = ^(w_head.value >> WIDTH) ^ w_full;

endmodule

// File: tb/tb_monitor_contador.sv
module tb_monitor_contador;
    import monitor_contador_pkg::*;

    localparam int WIDTH = 8;
    localparam int DEPTH = 4;

    typedef struct {
        logic [1:0] code;
        logic [7:0] value;
    } exp_t;

    logic                   clk = 1'b0;
    logic                   reset;
    logic [WIDTH-1:0]       cnt_value;
    logic                   cnt_en;
    logic                   cnt_dir;
    logic [WIDTH-1:0]       thresh;
    logic                   evt_valid;
    logic                   evt_ready;
    logic [1:0]             evt_code;
    logic [WIDTH-1:0]       evt_value;
    logic [$clog2(DEPTH):0] evt_count;
    logic                   evt_ovf;

    int   checks   = 0;
    int   failures = 0;
    exp_t sb_q[$];

    monitor_contador #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .cnt_value (cnt_value),
        .cnt_en    (cnt_en),
        .cnt_dir   (cnt_dir),
        .thresh    (thresh),
        .evt_valid (evt_valid),
        .evt_ready (evt_ready),
        .evt_code  (evt_code),
        .evt_value (evt_value),
        .evt_count (evt_count),
        .evt_ovf   (evt_ovf)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic en, input logic dir, input logic [7:0] val);
        cnt_en    = en;
        cnt_dir   = dir;
        cnt_value = val;
    endtask

    task automatic expect_evt(input logic [1:0] code, input logic [7:0] val);
        exp_t e;
        e.code  = code;
        e.value = val;
        sb_q.push_back(e);
    endtask

    // Compare the head with the scoreboard front, then accept it at the next edge.
    task automatic pop_check(input string tag);
        exp_t e;
        if (sb_q.size() == 0) begin
            checks++;
            failures++;
            $error("FAIL %s_sb observed=empty_scoreboard expected=entry", tag);
        end else begin
            e = sb_q.pop_front();
            check({tag, "_vld"},  evt_valid, 1'b1);
            check({tag, "_code"}, evt_code,  e.code);
            check({tag, "_val"},  evt_value, e.value);
        end
        evt_ready = 1'b1;
        tick();
        evt_ready = 1'b0;
    endtask

    initial begin
        reset     = 1'b1;
        evt_ready = 1'b0;
        thresh    = 8'h10;
        drive(1'b0, 1'b0, 8'h00);
        tick();
        tick();
        reset = 1'b0;
        check("rst_vld",   evt_valid, 1'b0);
        check("rst_code",  evt_code,  2'b00);
        check("rst_val",   evt_value, 8'h00);
        check("rst_cnt",   evt_count, 3'd0);
        check("rst_ovf",   evt_ovf,   1'b0);
        check("rst_state", dut.r_state, IDLE);

        // Up wrap: FD, FE, FF, 00.
        drive(1'b1, 1'b0, 8'hFD); tick();
        drive(1'b1, 1'b0, 8'hFE); tick();
        drive(1'b1, 1'b0, 8'hFF); tick();
        check("up_pre_vld", evt_valid, 1'b0);
        drive(1'b1, 1'b0, 8'h00); tick();
        expect_evt(2'b01, 8'h00);
        check("up_lat_vld", evt_valid, 1'b1);
        check("up_cnt", evt_count, 3'd1);
        pop_check("up_pop");
        check("up_post_cnt", evt_count, 3'd0);
        check("up_post_vld", evt_valid, 1'b0);

        // Down wrap: 01, 00, FF.
        drive(1'b1, 1'b1, 8'h01); tick();
        drive(1'b1, 1'b1, 8'h00); tick();
        check("dn_pre_vld", evt_valid, 1'b0);
        drive(1'b1, 1'b1, 8'hFF); tick();
        expect_evt(2'b10, 8'hFF);
        check("dn_cnt", evt_count, 3'd1);
        pop_check("dn_pop");
        check("dn_post_cnt", evt_count, 3'd0);

        // Disable for 3 cycles, re-enable at 01.
        drive(1'b0, 1'b1, 8'h00); tick();
        check("dis_state", dut.r_state, IDLE);
        tick();
        tick();
        check("dis_vld", evt_valid, 1'b0);
        drive(1'b1, 1'b1, 8'h01); tick();
        check("reen_state", dut.r_state, TRACK);
        check("reen_cnt", evt_count, 3'd0);
        tick();
        check("reen_cnt2", evt_count, 3'd0);

        // Fill and overflow: UP, DN, UP, DN retained, fifth UP dropped.
        drive(1'b1, 1'b0, 8'hFF); tick();
        drive(1'b1, 1'b0, 8'h00); tick(); expect_evt(2'b01, 8'h00);
        drive(1'b1, 1'b1, 8'hFF); tick(); expect_evt(2'b10, 8'hFF);
        drive(1'b1, 1'b0, 8'h00); tick(); expect_evt(2'b01, 8'h00);
        drive(1'b1, 1'b1, 8'hFF); tick(); expect_evt(2'b10, 8'hFF);
        check("full_cnt", evt_count, 3'd4);
        check("full_ovf_pre", evt_ovf, 1'b0);
        drive(1'b1, 1'b0, 8'h00); tick();
        check("ovf_cnt", evt_count, 3'd4);
        check("ovf_flag", evt_ovf, 1'b1);
        // Push and pop together while full.
        drive(1'b1, 1'b1, 8'hFF);
        pop_check("pp_pop");
        expect_evt(2'b10, 8'hFF);
        check("pp_cnt", evt_count, 3'd4);
        check("pp_ovf", evt_ovf, 1'b1);
        pop_check("drain0");
        pop_check("drain1");
        pop_check("drain2");
        pop_check("drain3");
        check("drain_cnt", evt_count, 3'd0);
        check("drain_vld", evt_valid, 1'b0);

        // Threshold at 00 coinciding with an up wrap: wrap only.
        thresh = 8'h00;
        drive(1'b1, 1'b0, 8'h00); tick();
        expect_evt(2'b01, 8'h00);
        check("thr0_cnt", evt_count, 3'd1);
        tick();
        check("thr0_cnt2", evt_count, 3'd1);
        pop_check("thr0_pop");
        check("thr0_post", evt_count, 3'd0);

        // Threshold at 10 on step 0F -> 10.
        thresh = 8'h10;
        drive(1'b1, 1'b0, 8'h0F); tick();
        check("thr_pre_cnt", evt_count, 3'd0);
        drive(1'b1, 1'b0, 8'h10); tick();
`ifdef MONITOR_THRESH_EN
        expect_evt(2'b11, 8'h10);
        check("thr_cnt", evt_count, 3'd1);
        pop_check("thr_pop");
`else
        check("thr_off_cnt", evt_count, 3'd0);
        check("thr_off_vld", evt_valid, 1'b0);
`endif

        // Reset with 3 events queued.
        drive(1'b1, 1'b0, 8'hFF); tick();
        drive(1'b1, 1'b0, 8'h00); tick();
        drive(1'b1, 1'b1, 8'hFF); tick();
        drive(1'b1, 1'b0, 8'h00); tick();
        check("q3_cnt", evt_count, 3'd3);
        check("q3_ovf", evt_ovf, 1'b1);
        reset = 1'b1;
        tick();
        check("mrst_vld",  evt_valid, 1'b0);
        check("mrst_cnt",  evt_count, 3'd0);
        check("mrst_ovf",  evt_ovf,   1'b0);
        check("mrst_code", evt_code,  2'b00);
        check("mrst_val",  evt_value, 8'h00);
        reset = 1'b0;
        sb_q.delete();
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/monitor_contador.md
# monitor_contador

Event monitor that sits directly downstream of the 8-bit up/down counter and consumes its count value together with its enable and direction controls. It detects wrap-around in either direction and, optionally, crossings of a programmable threshold. Detected events are buffered in a small FIFO and presented to the consumer over a valid/ready handshake.

## Interface
- `WIDTH`, default 8: counter value width.
- `DEPTH`, default 4: event FIFO depth; must be a power of 2 and at least 2.
- `clk` input, 1 bit: single clock; all logic acts on its rising edge.
- `reset` input, 1 bit: **synchronous, active-high** reset; one clock domain only.
- `cnt_value` input, WIDTH bits: counter output, sampled every cycle.
- `cnt_en` input, 1 bit: the counter's enable. When low, the counter forces 0.
- `cnt_dir` input, 1 bit: the counter's direction; 0 counts up, 1 counts down.
- `thresh` input, WIDTH bits: threshold value. Ignored unless the macro is defined.
- `evt_valid` output, 1 bit: the FIFO head holds an event.
- `evt_ready` input, 1 bit: the consumer accepts the head event.
- `evt_code` output, 2 bits: code of the head event (`evt_code_t`).
- `evt_value` output, WIDTH bits: `cnt_value` at the cycle the event was detected.
- `evt_count` output, $clog2(DEPTH)+1 bits: FIFO occupancy.
- `evt_ovf` output, 1 bit: sticky flag, set when an event is dropped because the FIFO is full.

## Operation
- FSM with two states:
  - IDLE: no valid previous sample held.
  - TRACK: `prev` (the previous `cnt_value`) is valid.
- FSM transitions:
  - IDLE→TRACK on any cycle with `cnt_en`=1; `prev` is loaded from `cnt_value`.
  - TRACK→IDLE on any cycle with `cnt_en`=0. No event is generated, so re-enable after the counter's forced clear never produces a false event.
  - In TRACK with `cnt_en`=1, `prev` is updated every cycle.
- Event detection happens only in TRACK with `cnt_en`=1, comparing `prev` against the current sample `cur`:
  - EVT_WRAP_UP (2'b01): `prev`=all-ones, `cur`=0, `cnt_dir`=0.
  - EVT_WRAP_DN (2'b10): `prev`=0, `cur`=all-ones, `cnt_dir`=1.
  - EVT_THRESH (2'b11, macro only): `cur`==`thresh` and `prev`!=`thresh`.
- Priority: a wrap event beats a threshold event in the same cycle. At most one event is generated per cycle.
- Equality checks are exact, unsigned, WIDTH-bit compares. Nothing is pushed if `prev`==`cur`.
- FIFO push/pop rules:
  - Push when an event is detected. Pop when `evt_valid`&&`evt_ready`.
  - Push while full without a pop: the event is dropped and `evt_ovf` is set to 1.
  - Push and pop in the same cycle while full: both are accepted, nothing is dropped, occupancy is unchanged.
  - Push and pop in the same cycle while empty: the push is accepted, the pop is ignored (`evt_valid` was 0).
  - Pointers wrap modulo DEPTH.
- Empty FIFO: `evt_valid`=0, `evt_code`=2'b00, `evt_value`=0.
- `evt_ovf` is cleared only by `reset`.
- Handshake: once asserted, `evt_valid` and the head data stay stable until accepted.

## Timing
- Reset values: state=IDLE, `prev`=0, FIFO empty, `evt_valid`=0, `evt_code`=0, `evt_value`=0, `evt_count`=0, `evt_ovf`=0.
- Reset mid-operation discards all buffered events and the overflow flag on the next edge.
- Latency: an event detected from the sample in cycle N gives `evt_valid`=1 in cycle N+1 (show-ahead FIFO, registered write).
- A pop at edge N updates the head, `evt_valid` and `evt_count` in cycle N+1.
- Throughput: one push and one pop per cycle.

## Configuration
- `MONITOR_THRESH_EN` defined: threshold comparator is present and EVT_THRESH events are generated.
- `MONITOR_THRESH_EN` undefined: no comparator logic is built, `thresh` is unused, and code 2'b11 never appears.

## Structure
- Package `monitor_contador_pkg` holds:
  - `evt_code_t` enum: EVT_NONE=0, EVT_WRAP_UP=1, EVT_WRAP_DN=2, EVT_THRESH=3.
  - `mon_state_t` enum: IDLE, TRACK.
  - Event record struct {code, value}.
- Sub-module `fifo_eventos`: parameterized synchronous FIFO (DEPTH, record type) with push/pop, full/empty, count and a drop indication.
- Top level contains the FSM, `prev` register, detectors and overflow flag.

## Test plan
- Reset, then `cnt_en`=1, `cnt_dir`=0, count 0xFD→0xFE→0xFF→0x00 → exactly one event, {WRAP_UP, 0x00}; `evt_valid` rises one cycle after the 0x00 sample.
- `cnt_dir`=1, count 0x01→0x00→0xFF → one event, {WRAP_DN, 0xFF}.
- `cnt_en` low for 3 cycles (value forced 0), then re-enable with value 0x01 → no event; FSM goes IDLE then TRACK.
- `evt_ready`=0, five wraps with DEPTH=4 → `evt_count`=4, `evt_ovf`=1, the first four events are retained in order; then push and pop together while full → count stays 4, no new drop.
- With `MONITOR_THRESH_EN` and `thresh`=0x00, up wrap 0xFF→0x00 → single WRAP_UP event only; with `thresh`=0x10 on the step 0x0F→0x10 → {THRESH, 0x10}.
- Assert `reset` while 3 events are queued → next cycle `evt_valid`=0, `evt_count`=0, `evt_ovf`=0.
